// File: rtl/seg_display_arbiter_if.sv
// Interface bundle for seg_display_arbiter: two display sources in, multiplexed
// seven-segment drive and overlay handshake out.
interface seg_display_arbiter_if;
  logic [15:0] src0_digits;
  logic [3:0]  src0_dots;
  logic        src1_req;
  logic [15:0] src1_digits;
  logic [3:0]  src1_dots;
  logic        src1_grant;
  logic        src1_done;
  logic        owner;
  logic [3:0]  anode;
  logic [6:0]  segment;
  logic        dot;

  modport master (
    output src0_digits, src0_dots, src1_req, src1_digits, src1_dots,
    input  src1_grant, src1_done, owner, anode, segment, dot
  );

  modport slave (
    input  src0_digits, src0_dots, src1_req, src1_digits, src1_dots,
    output src1_grant, src1_done, owner, anode, segment, dot
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// Four-digit multiplexed seven-segment driver shared between a background source
// and an overlay source; ownership changes only on frame boundaries.
module seg_display_arbiter #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int HOLD_CYCLES  = 200000000
) (
  input  logic                  clock,
  input  logic                  reset,
  seg_display_arbiter_if.slave  bus
);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {ST_BG, ST_PENDING, ST_OVL, ST_RELEASING} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    idx_q, idx_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    nib_q, nib_d;
  logic          dp_q, dp_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    seg_q, seg_d;
  logic          dot_q, dot_d;
  logic          done_q, done_d;
  logic          frame_tick;
  logic          owner_w;
  logic [15:0]   sel_digits;
  logic [3:0]    sel_dots;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign owner_w    = (state_q == ST_OVL) || (state_q == ST_RELEASING);
  assign frame_tick = (scan_q == SCAN_LAST) && (idx_q == 2'd3);
  assign sel_digits = owner_w ? bus.src1_digits : bus.src0_digits;
  assign sel_dots   = owner_w ? bus.src1_dots   : bus.src0_dots;

  // Scan timing, slot-start capture and registered display drive.
  always_comb begin
    scan_d  = (scan_q == SCAN_LAST) ? '0 : scan_q + SW'(1);
    idx_d   = (scan_q == SCAN_LAST) ? idx_q + 2'd1 : idx_q;
    nib_d   = nib_q;
    dp_d    = dp_q;
    anode_d = 4'b1111;
    seg_d   = 7'b1111111;
    dot_d   = 1'b1;
    if (scan_q == '0) begin
      nib_d = sel_digits[{idx_q, 2'b00} +: 4];
      dp_d  = sel_dots[idx_q];
    end
    // Lit cycles always follow the capture cycle within the same slot.
    if (scan_d >= BLANK_END) begin
      anode_d[idx_d] = 1'b0;
      seg_d          = hex7(nib_d);
      dot_d          = ~dp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    case (state_q)
      ST_BG: if (bus.src1_req) state_d = ST_PENDING;
      ST_PENDING: begin
        if (!bus.src1_req) begin
          state_d = ST_BG;
        end else if (frame_tick) begin
          state_d = ST_OVL;
          hold_d  = '0;
        end
      end
      ST_OVL: begin
        if (hold_q != HOLD_MAX) hold_d = hold_q + HW'(1);
        if (hold_q == HOLD_MAX && !bus.src1_req) state_d = ST_RELEASING;
      end
      default: begin
        if (frame_tick) begin
          state_d = ST_BG;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BG;
      scan_q  <= '0;
      idx_q   <= 2'd0;
      hold_q  <= '0;
      nib_q   <= 4'd0;
      dp_q    <= 1'b0;
      anode_q <= 4'b1111;
      seg_q   <= 7'b1111111;
      dot_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      nib_q   <= nib_d;
      dp_q    <= dp_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dot_q   <= dot_d;
      done_q  <= done_d;
    end
  end

  assign bus.src1_grant = owner_w;
  assign bus.owner      = owner_w;
  assign bus.src1_done  = done_q;
  assign bus.anode      = anode_q;
  assign bus.segment    = seg_q;
  assign bus.dot        = dot_q;
endmodule
